exec_cmd_gen: RTL and testbench

- Front-end that produces the execution-control commands consumed by the phase generator: `run`, `step_phase` and `step_inst` as clean one-cycle pulses.
- Sources are raw, bouncing, asynchronous push buttons plus a hardware breakpoint.
- Observes the phase generator's `running` and `cstate` outputs so a breakpoint stop lands exactly on IF, before the breakpointed instruction is fetched.
- Sits between the board I/O and the phase generator in the light-core top level.

---
 rtl/exec_cmd_gen.sv | 127 ++++++++++++
 tb/tb_exec_cmd_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_cmd_gen.sv
// Execution-control command generator: turns bouncing asynchronous buttons and a
// hardware breakpoint into clean one-cycle run / step_phase / step_inst pulses.

module exec_cmd_debounce #(
   parameter int DB_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level
);
   localparam int CW = $clog2(DB_CYCLES);

   logic [1:0]    sync_pipe;
   logic [CW-1:0] cnt;

   // level only follows after DB_CYCLES consecutive differing synchronized samples
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_pipe <= '0;
         cnt       <= '0;
         level     <= 1'b0;
      end else begin
         sync_pipe <= {sync_pipe[0], raw};
         if (sync_pipe[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYCLES - 1)) begin
            level <= sync_pipe[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

module exec_cmd_gen #(
   parameter int DB_CYCLES = 16,
   parameter int AW        = 32
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          btn_run,
   input  logic          btn_step_phase,
   input  logic          btn_step_inst,
   input  logic          running,
   input  logic [3:0]    cstate,
   input  logic [AW-1:0] next_pc,
   input  logic [AW-1:0] bp_addr,
   input  logic          bp_enable,
   output logic          run,
   output logic          step_phase,
   output logic          step_inst,
   output logic          bp_hit
);
   localparam int NUM_BTN = 3;
   localparam int BTN_RUN = 0;
   localparam int BTN_SI  = 1;
   localparam int BTN_SP  = 2;
   localparam logic [3:0] PH_EX = 4'b0100;

   // lockout: two cycles after any pulse in which no new user command is accepted
   typedef enum logic [1:0] {ARMED, LOCK_A, LOCK_B} lock_t;
   lock_t lock_q, lock_d;

   logic [NUM_BTN-1:0] btn_raw, db_lvl, db_q, req;
   logic bp_stop, acc_sp, acc_si, acc_run, user_acc, pulse;
   logic run_d, sp_d, si_d, hit_d;

   assign btn_raw = {btn_step_phase, btn_step_inst, btn_run};

   generate
      for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
         exec_cmd_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clock (clock),
            .reset (reset),
            .raw   (btn_raw[i]),
            .level (db_lvl[i])
         );
      end
   endgenerate

   assign req = db_lvl & ~db_q;

   always_comb begin
      // exact one-hot compare: malformed cstate never counts as EX
      bp_stop  = running && (cstate == PH_EX) && bp_enable && (next_pc == bp_addr);
      acc_sp   = 1'b0;
      acc_si   = 1'b0;
      acc_run  = 1'b0;
      if (lock_q == ARMED) begin
         if (req[BTN_SP] && !running)      acc_sp  = 1'b1;
         else if (req[BTN_SI] && !running) acc_si  = 1'b1;
         else if (req[BTN_RUN])            acc_run = 1'b1;
      end
      user_acc = acc_sp | acc_si | acc_run;
      // breakpoint and user run merge into one toggle
      run_d    = bp_stop | acc_run;
      sp_d     = acc_sp;
      si_d     = acc_si;
      pulse    = run_d | sp_d | si_d;
      hit_d    = bp_hit;
      if (bp_stop)       hit_d = 1'b1;
      else if (user_acc) hit_d = 1'b0;
      lock_d   = ARMED;
      if (pulse)                 lock_d = LOCK_A;
      else if (lock_q == LOCK_A) lock_d = LOCK_B;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_q     <= ARMED;
         db_q       <= '0;
         run        <= 1'b0;
         step_phase <= 1'b0;
         step_inst  <= 1'b0;
         bp_hit     <= 1'b0;
      end else begin
         lock_q     <= lock_d;
         db_q       <= db_lvl;
         run        <= run_d;
         step_phase <= sp_d;
         step_inst  <= si_d;
         bp_hit     <= hit_d;
      end
   end
endmodule

// File: tb/tb_exec_cmd_gen.sv
// Bench for exec_cmd_gen: directed scenarios plus random traffic against a
// cycle-level reference model and a small phase-generator model.

module tb_exec_cmd_gen;
   localparam int DB  = 16;
   localparam int AW  = 32;
   localparam int LAT = 2 + DB + 1;
   localparam int P_NONE = 0, P_SP = 1, P_SI = 2, P_RUN = 3;

   logic clock = 1'b0, reset = 1'b0;
   logic btn_run = 1'b0, btn_step_phase = 1'b0, btn_step_inst = 1'b0;
   logic running = 1'b0, bp_enable = 1'b0;
   logic [3:0] cstate = 4'b0001;
   logic [AW-1:0] next_pc = '0, bp_addr = '0;
   logic run, step_phase, step_inst, bp_hit;

   exec_cmd_gen #(.DB_CYCLES(DB), .AW(AW)) dut (
      .clock(clock), .reset(reset),
      .btn_run(btn_run), .btn_step_phase(btn_step_phase), .btn_step_inst(btn_step_inst),
      .running(running), .cstate(cstate), .next_pc(next_pc),
      .bp_addr(bp_addr), .bp_enable(bp_enable),
      .run(run), .step_phase(step_phase), .step_inst(step_inst), .bp_hit(bp_hit)
   );

   always #5 clock = ~clock;

   int errors = 0, checks = 0;
   int n_run, n_sp, n_si;

   // reference model: raw samples reach the debouncer two edges late
   logic [2:0] rawq[$];
   logic [2:0] seenq[$];
   logic [2:0] m_lvl, m_req;
   logic       m_hit;
   int         m_edge, m_last;

   // phase generator model
   bit pg_auto, pg_run, pg_stop_pend;
   int pg_phase;
   logic [AW-1:0] pg_pc;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      rawq.delete();
      rawq.push_back(3'b000);
      rawq.push_back(3'b000);
      seenq.delete();
      m_lvl = '0; m_req = '0; m_hit = 1'b0;
      m_edge = 0; m_last = -100;
   endtask

   task automatic tick();
      logic s_rst, s_run_i, s_bpen, bp, run_prev, all_diff;
      logic [3:0] s_cs, exp_o;
      logic [AW-1:0] s_npc, s_bpa;
      logic [2:0] s_raw, old;
      int pick;
      s_rst = reset; s_run_i = running; s_bpen = bp_enable; s_cs = cstate;
      s_npc = next_pc; s_bpa = bp_addr;
      s_raw = {btn_step_phase, btn_step_inst, btn_run};
      run_prev = run;
      @(posedge clock);
      #1;
      exp_o = 4'b0;
      if (s_rst) begin
         m_reset();
      end else begin
         m_edge++;
         bp = s_run_i && (s_cs == 4'b0100) && s_bpen && (s_npc == s_bpa);
         pick = P_NONE;
         if (m_edge - m_last > 2) begin
            if (m_req[2] && !s_run_i)      pick = P_SP;
            else if (m_req[1] && !s_run_i) pick = P_SI;
            else if (m_req[0])             pick = P_RUN;
         end
         exp_o[3] = bp || (pick == P_RUN);
         exp_o[2] = !bp && (pick == P_SP);
         exp_o[1] = !bp && (pick == P_SI);
         if (bp) m_hit = 1'b1;
         else if (pick != P_NONE) m_hit = 1'b0;
         exp_o[0] = m_hit;
         if (exp_o[3:1] != 3'b000) m_last = m_edge;
         seenq.push_back(rawq.pop_front());
         rawq.push_back(s_raw);
         if (seenq.size() > DB) void'(seenq.pop_front());
         old = m_lvl;
         if (seenq.size() == DB) begin
            for (int b = 0; b < 3; b++) begin
               all_diff = 1'b1;
               foreach (seenq[k]) if (seenq[k][b] == m_lvl[b]) all_diff = 1'b0;
               if (all_diff) m_lvl[b] = ~m_lvl[b];
            end
         end
         m_req = m_lvl & ~old;
      end
      check("outputs", {run, step_phase, step_inst, bp_hit}, exp_o);
      n_run += int'(run); n_sp += int'(step_phase); n_si += int'(step_inst);
      if (pg_auto) begin
         if (!pg_run) begin
            if (run_prev) pg_run = 1'b1;
         end else begin
            if (run_prev) pg_stop_pend = 1'b1;
            if (pg_phase == 3) begin
               pg_phase = 0;
               pg_pc += 4;
               if (pg_stop_pend) begin pg_run = 1'b0; pg_stop_pend = 1'b0; end
            end else begin
               pg_phase++;
            end
         end
         running = pg_run;
         cstate  = 4'b0001 << pg_phase;
         next_pc = pg_pc + 4;
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic clr_cnt();
      n_run = 0; n_sp = 0; n_si = 0;
   endtask

   initial begin
      int lat, k;
      m_reset(); clr_cnt(); pg_auto = 0;
      #1 reset = 1'b1;
      cycles(2);
      check("reset_outputs", {run, step_phase, step_inst, bp_hit}, 4'b0);
      reset = 1'b0;
      cycles(4);

      // bouncing button, then a clean hold
      clr_cnt();
      for (int s = 0; s < 14; s++) begin btn_run = (s % 2 == 0); cycles(3); end
      check("bounce_quiet", n_run, 0);
      btn_run = 1'b1; lat = 0;
      while (run !== 1'b1 && lat < 60) begin tick(); lat++; end
      check("db_latency", lat, LAT);
      cycles(10);
      check("db_single_pulse", n_run, 1);
      btn_run = 1'b0; cycles(DB + 6);

      // simultaneous step_phase and run: step_phase wins
      clr_cnt();
      btn_step_phase = 1'b1; btn_run = 1'b1; cycles(LAT + 6);
      check("prio_sp", n_sp, 1);
      check("prio_run_dropped", n_run, 0);
      btn_step_phase = 1'b0; btn_run = 1'b0; cycles(DB + 6);

      // step while running is dropped
      clr_cnt();
      running = 1'b1; cstate = 4'b0100;
      btn_step_inst = 1'b1; cycles(LAT + 6);
      check("step_blocked", n_si + n_sp + n_run, 0);
      btn_step_inst = 1'b0; cycles(DB + 6);

      // start then stop
      clr_cnt();
      running = 1'b0; cstate = 4'b0001;
      btn_run = 1'b1; cycles(LAT + 4); btn_run = 1'b0; cycles(DB + 6);
      running = 1'b1;
      btn_run = 1'b1; cycles(LAT + 4); btn_run = 1'b0;
      check("start_stop_pulses", n_run, 2);
      cycles(DB + 6); running = 1'b0;

      // breakpoint stop with the phase generator model
      bp_enable = 1'b1; bp_addr = 32'h0000_0040;
      pg_pc = 32'h34; pg_phase = 0; pg_run = 0; pg_stop_pend = 0; pg_auto = 1;
      cstate = 4'b0001; next_pc = 32'h38;
      btn_run = 1'b1; k = 0;
      while (!pg_run && k < 60) begin tick(); k++; end
      check("pg_started", pg_run, 1);
      btn_run = 1'b0; clr_cnt(); k = 0;
      while (pg_run && k < 100) begin tick(); k++; end
      check("bp_stopped", pg_run, 0);
      check("bp_stop_pc", pg_pc, 32'h40);
      check("bp_stop_if", cstate, 4'b0001);
      check("bp_hit_set", bp_hit, 1);
      check("bp_one_pulse", n_run, 1);
      cycles(DB + 6);
      check("bp_stays_stopped", pg_run, 0);

      // resume: bp_hit clears, 0x40 executes without a re-stop
      btn_run = 1'b1; k = 0;
      while (!pg_run && k < 60) begin tick(); k++; end
      check("resume_started", pg_run, 1);
      check("bp_hit_clear", bp_hit, 0);
      btn_run = 1'b0; cycles(DB + 6);
      check("resume_no_restop", pg_run, 1);
      check("resume_progress", pg_pc > 32'h40, 1);
      btn_run = 1'b1; k = 0;
      while (pg_run && k < 100) begin tick(); k++; end
      check("user_stop", pg_run, 0);
      btn_run = 1'b0; pg_auto = 0; bp_enable = 1'b0;
      running = 1'b0; cstate = 4'b0001;
      cycles(DB + 6);

      // reset mid-debounce, then held button yields one fresh pulse
      btn_step_phase = 1'b1; cycles(8);
      #2 reset = 1'b1;
      #1 check("rst_async_debounce", {run, step_phase, step_inst, bp_hit}, 4'b0);
      tick(); reset = 1'b0; lat = 0;
      while (step_phase !== 1'b1 && lat < 60) begin tick(); lat++; end
      check("rst_hold_latency", lat, LAT);
      // reset while the pulse is high (lockout active)
      #2 reset = 1'b1;
      #1 check("rst_async_lockout", {run, step_phase, step_inst, bp_hit}, 4'b0);
      tick(); reset = 1'b0; lat = 0;
      while (step_phase !== 1'b1 && lat < 60) begin tick(); lat++; end
      check("rst_hold_latency2", lat, LAT);
      btn_step_phase = 1'b0; cycles(DB + 6);

      // random traffic against the model
      bp_addr = $urandom;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 19) == 0) btn_run = ~btn_run;
         if ($urandom_range(0, 23) == 0) btn_step_phase = ~btn_step_phase;
         if ($urandom_range(0, 21) == 0) btn_step_inst = ~btn_step_inst;
         if ($urandom_range(0, 7) == 0) running = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 31) == 0) bp_enable = ~bp_enable;
         case ($urandom_range(0, 4))
            0: cstate = 4'b0001;
            1: cstate = 4'b0010;
            2: cstate = 4'b0100;
            3: cstate = 4'b1000;
            default: cstate = 4'($urandom);
         endcase
         next_pc = ($urandom_range(0, 1) == 1) ? bp_addr : bp_addr + 4;
         if ($urandom_range(0, 499) == 0) begin
            reset = 1'b1; tick(); reset = 1'b0;
         end else begin
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
